// File: rtl/demux_pkg.sv
// Shared encodings for the 4-bit 1-to-2 demux scheduler: routing policies and FSM states.
package demux_pkg;

    localparam int BCNT_W = 4;

    typedef enum logic [1:0] {
        MODE_CH0   = 2'b00,
        MODE_CH1   = 2'b01,
        MODE_ALT   = 2'b10,
        MODE_BURST = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/demux_sel_policy.sv
// Routing policy: picks the target channel for an accepted word and the next policy state.
// Purely combinational; the caller commits the next-state values only on an accept.
module demux_sel_policy
    import demux_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  mode_t             mode_q,
    input  logic              rr_sel,
    input  logic [BCNT_W-1:0] burst_cnt,
    output logic              target,
    output logic              rr_sel_nxt,
    output logic [BCNT_W-1:0] burst_cnt_nxt
);

    always_comb begin
        target        = 1'b0;
        rr_sel_nxt    = rr_sel;
        burst_cnt_nxt = burst_cnt;
        case (mode_q)
            MODE_CH0: target = 1'b0;
            MODE_CH1: target = 1'b1;
            MODE_ALT: begin
                target     = rr_sel;
                rr_sel_nxt = ~rr_sel;
            end
            default: begin
                target = rr_sel;
                // Last word of a burst: restart the count and swap channels.
                if (burst_cnt == BCNT_W'(BURST_LEN - 1)) begin
                    burst_cnt_nxt = '0;
                    rr_sel_nxt    = ~rr_sel;
                end else begin
                    burst_cnt_nxt = burst_cnt + BCNT_W'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/demux_sched_4bits.sv
// 1-to-2 demux scheduler: holds one word, routes it by policy, counts deliveries per channel.
// One-cycle latency; a held word stays put until its consumer takes it, with pass-through at 1 word/cycle.
module demux_sched_4bits
    import demux_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic              sel,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic              busy
);

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   hold_data;
    mode_t               mode_q;
    logic                rr_sel;
    logic [BCNT_W-1:0]   burst_cnt;
    logic                target;
    logic                rr_sel_nxt;
    logic [BCNT_W-1:0]   burst_cnt_nxt;
    logic                deliver0;
    logic                deliver1;
    logic                deliver;
    logic                accept;

    demux_sel_policy #(.BURST_LEN(BURST_LEN)) u_policy (
        .mode_q        (mode_q),
        .rr_sel        (rr_sel),
        .burst_cnt     (burst_cnt),
        .target        (target),
        .rr_sel_nxt    (rr_sel_nxt),
        .burst_cnt_nxt (burst_cnt_nxt)
    );

    assign busy       = (state == HOLD);
    assign out0_valid = busy && !sel;
    assign out1_valid = busy && sel;
    assign out0_data  = out0_valid ? hold_data : '0;
    assign out1_data  = out1_valid ? hold_data : '0;
    assign deliver0   = out0_valid && out0_ready;
    assign deliver1   = out1_valid && out1_ready;
    assign deliver    = deliver0 || deliver1;
    assign in_ready   = rst_n && (state == IDLE || deliver);
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = HOLD;
            HOLD: if (deliver && !accept) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_data <= '0;
            sel       <= 1'b0;
            mode_q    <= MODE_CH0;
            rr_sel    <= 1'b0;
            burst_cnt <= '0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_data <= in_data;
                sel       <= target;
                rr_sel    <= rr_sel_nxt;
                burst_cnt <= burst_cnt_nxt;
            end else if (state == IDLE) begin
                // Policy changes only land on a quiet idle cycle so a stream never splits mid-policy.
                mode_q <= mode_t'(mode);
                if (mode != mode_q) begin
                    rr_sel    <= 1'b0;
                    burst_cnt <= '0;
                end
            end
            if (deliver0) cnt0 <= cnt0 + CNT_W'(1);
            if (deliver1) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_sched_4bits.sv
// Self-checking bench for demux_sched_4bits: directed scenarios plus randomized streams vs a policy model.
module tb_demux_sched_4bits;

    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out0_data;
    logic       out0_valid;
    logic       out0_ready = 1'b1;
    logic [3:0] out1_data;
    logic       out1_valid;
    logic       out1_ready = 1'b1;
    logic       sel;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: latched policy and words routed under it since it was latched.
    logic [1:0] model_mode = 2'b00;
    int         model_n    = 0;
    logic [7:0] exp_cnt0   = 8'd0;
    logic [7:0] exp_cnt1   = 8'd0;
    logic [4:0] exp_q[$];
    logic [4:0] dl_q[$];

    always #5 clk = ~clk;

    demux_sched_4bits #(.DATA_W(4), .BURST_LEN(BL), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .sel        (sel),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .busy       (busy)
    );

    // Delivery monitor: records {channel, data} of every completed output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out0_valid && out0_ready) dl_q.push_back({1'b0, out0_data});
            if (out1_valid && out1_ready) dl_q.push_back({1'b1, out1_data});
        end
    end

    function automatic logic policy_target(input logic [1:0] m, input int n);
        case (m)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return n[0];
            default: return ((n / BL) % 2) == 1;
        endcase
    endfunction

    task automatic model_reset();
        model_mode = 2'b00;
        model_n    = 0;
        exp_cnt0   = 8'd0;
        exp_cnt1   = 8'd0;
    endtask

    task automatic model_accept(input logic [3:0] d);
        logic ch;
        ch = policy_target(model_mode, model_n);
        if (model_mode[1]) model_n++;
        exp_q.push_back({ch, d});
        if (ch) exp_cnt1++;
        else    exp_cnt0++;
    endtask

    // Drives a stream of random words under mode m after idle cycles that let the mode latch.
    task automatic stream(input logic [1:0] m, input int nwords, input int vld_pct, input int rdy_pct);
        int sent = 0;
        int cyc  = 0;
        @(posedge clk); #1;
        mode = m; in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (m != model_mode) begin
            model_mode = m;
            model_n    = 0;
        end
        exp_q.delete();
        dl_q.delete();
        while ((sent < nwords || dl_q.size() < exp_q.size()) && cyc < 4000) begin
            in_valid   = (sent < nwords) && ($urandom_range(99) < vld_pct);
            in_data    = 4'($urandom_range(15));
            out0_ready = $urandom_range(99) < rdy_pct;
            out1_ready = $urandom_range(99) < rdy_pct;
            @(negedge clk);
            if (in_valid && in_ready) begin
                model_accept(in_data);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 4'h5; mode = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b%b want 00", out0_valid, out1_valid); end
        n_checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1); end
        n_checks++; if (sel !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_sel_busy: got %b/%b want 0/0", sel, busy); end
        n_checks++; if (out0_data !== 4'h0 || out1_data !== 4'h0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", out0_data, out1_data); end
        @(posedge clk); #1;
        in_valid = 1'b0; mode = 2'b00; rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_ch0();
        mode = 2'b00; in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            in_data  = 4'(i + 1);
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fixed_in_ready[%0d]: got %b want 1", i, in_ready); end
            n_checks++; if (out0_valid !== (i > 0 && i < 4)) begin n_err++; $display("FAIL fixed_out0_valid[%0d]: got %b want %b", i, out0_valid, (i > 0 && i < 4)); end
            if (i > 0 && i < 4) begin
                n_checks++; if (out0_data !== 4'(i)) begin n_err++; $display("FAIL fixed_out0_data[%0d]: got %h want %h", i, out0_data, 4'(i)); end
            end
            n_checks++; if (out1_valid !== 1'b0 || out1_data !== 4'h0) begin n_err++; $display("FAIL fixed_out1_idle[%0d]: got %b/%h want 0/0", i, out1_valid, out1_data); end
            @(posedge clk); #1;
        end
        exp_cnt0 = exp_cnt0 + 8'd3;
        n_checks++; if (cnt0 !== exp_cnt0) begin n_err++; $display("FAIL fixed_cnt0: got %0d want %0d", cnt0, exp_cnt0); end
    endtask

    task automatic test_alternate();
        stream(2'b10, 4, 100, 100);
        n_checks++; if (dl_q.size() != 4) begin n_err++; $display("FAIL alt_count: got %0d want 4", dl_q.size()); end
        for (int i = 0; i < 4 && i < dl_q.size(); i++) begin
            n_checks++; if (dl_q[i] !== exp_q[i]) begin n_err++; $display("FAIL alt_word[%0d]: got %h want %h", i, dl_q[i], exp_q[i]); end
            n_checks++; if (dl_q[i][4] !== 1'(i % 2)) begin n_err++; $display("FAIL alt_chan[%0d]: got %b want %0d", i, dl_q[i][4], i % 2); end
        end
        n_checks++; if (cnt0 !== exp_cnt0 || cnt1 !== exp_cnt1) begin n_err++; $display("FAIL alt_cnt: got %0d/%0d want %0d/%0d", cnt0, cnt1, exp_cnt0, exp_cnt1); end
    endtask

    task automatic test_burst();
        logic [7:0] c0_start = cnt0;
        logic [7:0] c1_start = cnt1;
        stream(2'b11, 10, 100, 100);
        n_checks++; if (dl_q.size() != 10) begin n_err++; $display("FAIL burst_count: got %0d want 10", dl_q.size()); end
        for (int i = 0; i < 10 && i < dl_q.size(); i++) begin
            n_checks++; if (dl_q[i] !== exp_q[i]) begin n_err++; $display("FAIL burst_word[%0d]: got %h want %h", i, dl_q[i], exp_q[i]); end
            n_checks++; if (dl_q[i][4] !== !(i < 4 || i >= 8)) begin n_err++; $display("FAIL burst_chan[%0d]: got %b want %b", i, dl_q[i][4], !(i < 4 || i >= 8)); end
        end
        n_checks++; if (cnt0 - c0_start !== 8'd6 || cnt1 - c1_start !== 8'd4) begin n_err++; $display("FAIL burst_cnt_delta: got %0d/%0d want 6/4", cnt0 - c0_start, cnt1 - c1_start); end
    endtask

    task automatic test_backpressure();
        mode = 2'b01; in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        @(posedge clk); #1;
        model_mode = 2'b01; model_n = 0;
        in_valid = 1'b1; in_data = 4'h9; out1_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 4'h5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (out1_valid !== 1'b1 || out1_data !== 4'h9) begin n_err++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/9", i, out1_valid, out1_data); end
            n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || sel !== 1'b1) begin n_err++; $display("FAIL bp_stall[%0d]: in_ready/busy/sel got %b%b%b want 011", i, in_ready, busy, sel); end
            @(posedge clk); #1;
        end
        out1_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_cnt1 = exp_cnt1 + 8'd1;
        @(negedge clk);
        n_checks++; if (cnt1 !== exp_cnt1) begin n_err++; $display("FAIL bp_cnt1: got %0d want %0d", cnt1, exp_cnt1); end
        n_checks++; if (out1_valid !== 1'b1 || out1_data !== 4'h5) begin n_err++; $display("FAIL bp_next_word: got %b/%h want 1/5", out1_valid, out1_data); end
        @(posedge clk); #1;
        exp_cnt1 = exp_cnt1 + 8'd1;
        @(negedge clk);
        n_checks++; if (cnt1 !== exp_cnt1 || busy !== 1'b0) begin n_err++; $display("FAIL bp_drain: cnt1/busy got %0d/%b want %0d/0", cnt1, busy, exp_cnt1); end
        @(posedge clk); #1;
    endtask

    task automatic test_mode_change();
        mode = 2'b10; in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 4'hA;
        @(posedge clk); #1;
        mode = 2'b00; in_data = 4'hB;
        @(posedge clk); #1;
        in_data = 4'hC;
        @(negedge clk);
        n_checks++; if (sel !== 1'b1 || out1_data !== 4'hB) begin n_err++; $display("FAIL mc_old_mode_b: sel/data got %b/%h want 1/b", sel, out1_data); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (sel !== 1'b0 || out0_data !== 4'hC) begin n_err++; $display("FAIL mc_old_mode_c: sel/data got %b/%h want 0/c", sel, out0_data); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL mc_idle: busy got %b want 0", busy); end
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 4'hD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (sel !== 1'b0 || out0_data !== 4'hD) begin n_err++; $display("FAIL mc_new_mode_d: sel/data got %b/%h want 0/d", sel, out0_data); end
        @(posedge clk); #1;
        mode = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 4'hE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (sel !== 1'b0 || out0_data !== 4'hE) begin n_err++; $display("FAIL mc_rr_cleared: sel/data got %b/%h want 0/e", sel, out0_data); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_cnt0 = exp_cnt0 + 8'd4;
        exp_cnt1 = exp_cnt1 + 8'd1;
        model_mode = 2'b10; model_n = 1;
        n_checks++; if (cnt0 !== exp_cnt0 || cnt1 !== exp_cnt1) begin n_err++; $display("FAIL mc_cnt: got %0d/%0d want %0d/%0d", cnt0, cnt1, exp_cnt0, exp_cnt1); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            logic [1:0] m;
            m = 2'($urandom_range(3));
            stream(m, 30, $urandom_range(50, 100), $urandom_range(30, 100));
            n_checks++; if (dl_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", r, dl_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < dl_q.size(); i++) begin
                n_checks++; if (dl_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_word[%0d.%0d] mode %b: got %h want %h", r, i, m, dl_q[i], exp_q[i]); end
            end
            n_checks++; if (cnt0 !== exp_cnt0 || cnt1 !== exp_cnt1) begin n_err++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", r, cnt0, cnt1, exp_cnt0, exp_cnt1); end
        end
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        stream(2'b00, 255, 100, 100);
        n_checks++; if (cnt0 !== 8'd255 || cnt0 !== exp_cnt0) begin n_err++; $display("FAIL wrap_pre: got %0d want 255", cnt0); end
        stream(2'b00, 1, 100, 100);
        n_checks++; if (cnt0 !== 8'd0 || cnt0 !== exp_cnt0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", cnt0); end
        n_checks++; if (cnt1 !== 8'd0) begin n_err++; $display("FAIL wrap_cnt1: got %0d want 0", cnt1); end
    endtask

    initial begin
        test_reset();
        test_fixed_ch0();
        test_alternate();
        test_burst();
        test_backpressure();
        test_mode_change();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
